// File: rtl/tiny45_mem_arbiter_pkg.sv
// Shared types for the tiny45 memory arbiter: FSM state encoding, access size
// codes and the mapping from access size to memory transaction length.
package tiny45_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IFETCH = 2'd1,
        ST_DREAD  = 2'd2,
        ST_DWRITE = 2'd3
    } arb_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [3:0] FETCH_NIBBLES = 4'd8;

    // Code 11 is not a legal size and is widened to a word access.
    function automatic logic [3:0] size_to_nibbles(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 4'd2;
            SIZE_HALF: return 4'd4;
            default:   return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/tiny45_mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-port signals around the arbiter.
// The master modport is the arbiter's view; slave is the surrounding system.
interface tiny45_mem_arbiter_if #(parameter int ADDR_BITS = 28);

    logic                 instr_req;
    logic [ADDR_BITS-1:0] instr_addr;
    logic                 instr_flush;
    logic                 instr_gnt;
    logic [3:0]           instr_rdata;
    logic                 instr_rvalid;

    logic                 data_req;
    logic [ADDR_BITS-1:0] data_addr;
    logic                 data_write;
    logic [1:0]           data_size;
    logic [3:0]           data_wdata;
    logic                 data_wready;
    logic                 data_gnt;
    logic [3:0]           data_rdata;
    logic                 data_rvalid;
    logic                 data_done;

    logic                 mem_start;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_write;
    logic [3:0]           mem_nibbles;
    logic [3:0]           mem_wdata;
    logic                 mem_wready;
    logic [3:0]           mem_rdata;
    logic                 mem_rvalid;

    modport master (
        input  instr_req, instr_addr, instr_flush,
        output instr_gnt, instr_rdata, instr_rvalid,
        input  data_req, data_addr, data_write, data_size, data_wdata,
        output data_wready, data_gnt, data_rdata, data_rvalid, data_done,
        output mem_start, mem_addr, mem_write, mem_nibbles, mem_wdata,
        input  mem_wready, mem_rdata, mem_rvalid
    );

    modport slave (
        output instr_req, instr_addr, instr_flush,
        input  instr_gnt, instr_rdata, instr_rvalid,
        output data_req, data_addr, data_write, data_size, data_wdata,
        input  data_wready, data_gnt, data_rdata, data_rvalid, data_done,
        input  mem_start, mem_addr, mem_write, mem_nibbles, mem_wdata,
        output mem_wready, mem_rdata, mem_rvalid
    );

endinterface

// File: rtl/tiny45_mem_arbiter.sv
// Arbitrates fetch and load/store requests onto one nibble-serial memory port
// and steers read/write nibbles between memory and the winning requester.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no transaction; arbitrate between pending requests
//   ST_IFETCH | 8-nibble instruction read in flight (may be flushed)
//   ST_DREAD  | load in flight, nibbles steered to data_rdata
//   ST_DWRITE | store in flight, data_wdata steered to memory
module tiny45_mem_arbiter
    import tiny45_mem_pkg::*;
#(
    parameter int ADDR_BITS = 28
) (
    input logic                 clk,
    input logic                 rstn,
    tiny45_mem_arbiter_if.master bus
);

    arb_state_e           state_q, state_d;
    logic                 last_data_q;
    logic                 flushed_q;
    logic [3:0]           cnt_q;
    logic [3:0]           nibbles_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 write_q;
    logic                 start_q;
    logic                 instr_gnt_q;
    logic                 data_gnt_q;

    logic instr_req_eff;
    logic data_win;
    logic instr_win;
    logic hs;
    logic last_hs;
    logic instr_rvalid;
    logic data_rvalid;
    logic data_wready;
    logic data_done;

    // Data normally wins, but never twice in a row while a fetch waits.
    assign instr_req_eff = bus.instr_req && !bus.instr_flush;
    assign data_win      = bus.data_req && (!last_data_q || !instr_req_eff);
    assign instr_win     = !data_win && instr_req_eff;

    always_comb begin
        hs = 1'b0;
        case (state_q)
            ST_IFETCH, ST_DREAD: hs = bus.mem_rvalid;
            ST_DWRITE:           hs = bus.mem_wready;
            default:             hs = 1'b0;
        endcase
    end

    assign last_hs = hs && (cnt_q == nibbles_q - 4'd1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (data_win)       state_d = bus.data_write ? ST_DWRITE : ST_DREAD;
                else if (instr_win) state_d = ST_IFETCH;
            end
            default: begin
                if (last_hs) state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        instr_rvalid = 1'b0;
        data_rvalid  = 1'b0;
        data_wready  = 1'b0;
        data_done    = 1'b0;
        case (state_q)
            ST_IFETCH: instr_rvalid = bus.mem_rvalid && !flushed_q && !bus.instr_flush;
            ST_DREAD: begin
                data_rvalid = bus.mem_rvalid;
                data_done   = last_hs;
            end
            ST_DWRITE: begin
                data_wready = bus.mem_wready;
                data_done   = last_hs;
            end
            default: ;
        endcase
    end

    // Transaction attributes are captured at grant and held for the memory.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_data_q <= 1'b0;
            flushed_q   <= 1'b0;
            cnt_q       <= 4'd0;
            nibbles_q   <= 4'd0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            start_q     <= 1'b0;
            instr_gnt_q <= 1'b0;
            data_gnt_q  <= 1'b0;
        end else begin
            start_q     <= 1'b0;
            instr_gnt_q <= 1'b0;
            data_gnt_q  <= 1'b0;
            if (state_q == ST_IDLE) begin
                flushed_q <= 1'b0;
                if (data_win || instr_win) begin
                    start_q     <= 1'b1;
                    instr_gnt_q <= instr_win;
                    data_gnt_q  <= data_win;
                    last_data_q <= data_win;
                    cnt_q       <= 4'd0;
                    addr_q      <= data_win ? bus.data_addr : bus.instr_addr;
                    write_q     <= data_win && bus.data_write;
                    nibbles_q   <= data_win ? size_to_nibbles(bus.data_size) : FETCH_NIBBLES;
                end
            end else begin
                if (hs) cnt_q <= cnt_q + 4'd1;
                if (state_q == ST_IFETCH && bus.instr_flush) flushed_q <= 1'b1;
            end
        end
    end

    assign bus.instr_gnt    = instr_gnt_q;
    assign bus.data_gnt     = data_gnt_q;
    assign bus.mem_start    = start_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_write    = write_q;
    assign bus.mem_nibbles  = nibbles_q;
    assign bus.mem_wdata    = bus.data_wdata;
    assign bus.instr_rdata  = bus.mem_rdata;
    assign bus.data_rdata   = bus.mem_rdata;
    assign bus.instr_rvalid = instr_rvalid;
    assign bus.data_rvalid  = data_rvalid;
    assign bus.data_wready  = data_wready;
    assign bus.data_done    = data_done;

endmodule

// File: tb/tb_tiny45_mem_arbiter.sv
// Directed and randomized bench for tiny45_mem_arbiter with a transaction-level
// model of arbitration, transfer length, steering and flush behaviour.
module tb_tiny45_mem_arbiter;
    import tiny45_mem_pkg::*;

    localparam int AW = 28;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    tiny45_mem_arbiter_if #(.ADDR_BITS(AW)) bus ();
    tiny45_mem_arbiter #(.ADDR_BITS(AW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    bit prev_data = 1'b0;
    bit pulse_pending = 1'b0;
    logic [3:0] wq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nib_of(input logic [1:0] size);
        return (size >= 2'd2) ? 8 : (2 << size);
    endfunction

    task automatic set_fetch(input logic [AW-1:0] a);
        bus.instr_addr = a;
        bus.instr_req  = 1'b1;
    endtask

    task automatic set_data(input logic [AW-1:0] a, input bit w, input logic [1:0] s);
        bus.data_addr  = a;
        bus.data_write = w;
        bus.data_size  = s;
        bus.data_req   = 1'b1;
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_pulses"}, {bus.instr_gnt, bus.data_gnt, bus.mem_start, bus.data_done}, 0);
        chk({pfx, "_valids"}, {bus.instr_rvalid, bus.data_rvalid, bus.data_wready}, 0);
        chk({pfx, "_mem_addr"}, bus.mem_addr, 0);
        chk({pfx, "_mem_ctl"}, {bus.mem_write, bus.mem_nibbles}, 0);
    endtask

    task automatic step();
        @(negedge clk);
        bus.instr_flush = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_wready  = 1'b0;
        if (pulse_pending) begin
            chk("gnt_one_cycle", {bus.mem_start, bus.instr_gnt, bus.data_gnt}, 0);
            pulse_pending = 1'b0;
        end
    endtask

    // Waits for the grant, then plays the memory side of one transaction.
    task automatic serve(input bit exp_data, input logic [AW-1:0] exp_addr, input bit exp_write,
                         input int exp_nib, input int flush_at, input int stop_at);
        int waits = 0;
        bit got = 1'b0;
        bit flushed = 1'b0;
        int ipulses = 0;
        logic [3:0] nib;
        while (!got && waits < 20) begin
            @(negedge clk);
            waits++;
            got = bus.instr_gnt || bus.data_gnt;
        end
        chk("grant_seen", got, 1);
        if (!got) return;
        chk("grant_latency", waits, 1);
        chk("data_gnt", bus.data_gnt, exp_data);
        chk("instr_gnt", bus.instr_gnt, !exp_data);
        chk("mem_start", bus.mem_start, 1);
        chk("mem_addr", bus.mem_addr, exp_addr);
        chk("mem_write", bus.mem_write, exp_write);
        chk("mem_nibbles", bus.mem_nibbles, exp_nib);
        prev_data = exp_data;
        pulse_pending = 1'b1;
        if (exp_data) bus.data_req = 1'b0;
        else          bus.instr_req = 1'b0;
        for (int k = 0; k < exp_nib; k++) begin
            int gap;
            if (k == stop_at) return;
            gap = $urandom_range(0, 2);
            if (k == flush_at && gap == 0) gap = 1;
            for (int g = 0; g < gap; g++) begin
                if (k == flush_at && g == 0) begin
                    bus.instr_flush = 1'b1;
                    flushed = 1'b1;
                end
                // the opposite handshake must be ignored
                if (exp_write) bus.mem_rvalid = 1'($urandom_range(0, 1));
                else           bus.mem_wready = 1'($urandom_range(0, 1));
                #1;
                chk("quiet_cycle", {bus.instr_rvalid, bus.data_rvalid, bus.data_wready, bus.data_done}, 0);
                step();
            end
            nib = (wq.size() > 0) ? wq.pop_front() : 4'($urandom_range(0, 15));
            if (exp_write) begin
                bus.data_wdata = nib;
                bus.mem_wready = 1'b1;
            end else begin
                bus.mem_rdata  = nib;
                bus.mem_rvalid = 1'b1;
            end
            #1;
            chk("mem_addr_held", bus.mem_addr, exp_addr);
            if (exp_write) begin
                chk("data_wready", bus.data_wready, 1);
                chk("mem_wdata", bus.mem_wdata, nib);
            end else if (exp_data) begin
                chk("data_rvalid", bus.data_rvalid, 1);
                chk("data_rdata", bus.data_rdata, nib);
            end else begin
                chk("instr_rvalid", bus.instr_rvalid, !flushed);
                if (bus.instr_rvalid) ipulses++;
                if (!flushed) chk("instr_rdata", bus.instr_rdata, nib);
            end
            chk("data_done", bus.data_done, exp_data && (k == exp_nib - 1));
            step();
        end
        if (!exp_data) chk("fetch_pulses", ipulses, (flush_at >= 0) ? flush_at : exp_nib);
        bus.mem_rvalid = 1'b1;
        bus.mem_wready = 1'b1;
        #1;
        chk("idle_ignore", {bus.instr_rvalid, bus.data_rvalid, bus.data_wready, bus.data_done}, 0);
        bus.mem_rvalid = 1'b0;
        bus.mem_wready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit pi = 1'b0;
        bit pd = 1'b0;
        logic [AW-1:0] ia = '0;
        logic [AW-1:0] da = '0;
        bit dw = 1'b0;
        logic [1:0] ds = 2'b00;
        int fl;

        rstn = 1'b0;
        bus.instr_req = 1'b0;  bus.instr_addr = '0;  bus.instr_flush = 1'b0;
        bus.data_req = 1'b0;   bus.data_addr = '0;   bus.data_write = 1'b0;
        bus.data_size = 2'b00; bus.data_wdata = 4'h0;
        bus.mem_wready = 1'b0; bus.mem_rdata = 4'h0; bus.mem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rstn = 1'b1;

        // load word at 0x100
        set_data(AW'('h100), 1'b0, SIZE_WORD);
        serve(1'b1, AW'('h100), 1'b0, 8, -1, -1);

        // store byte 0xA, 0x5
        wq.push_back(4'hA);
        wq.push_back(4'h5);
        set_data(AW'('h104), 1'b1, SIZE_BYTE);
        serve(1'b1, AW'('h104), 1'b1, 2, -1, -1);

        // fetch flushed after three nibbles still drains all eight
        set_fetch(AW'('h200));
        serve(1'b0, AW'('h200), 1'b0, 8, 3, -1);

        // both pending: data first, then fetch even with data re-requested
        set_fetch(AW'('h204));
        set_data(AW'('h300), 1'b0, SIZE_HALF);
        serve(1'b1, AW'('h300), 1'b0, 4, -1, -1);
        set_data(AW'('h304), 1'b1, SIZE_WORD);
        serve(1'b0, AW'('h204), 1'b0, 8, -1, -1);
        serve(1'b1, AW'('h304), 1'b1, 8, -1, -1);

        // size 11 widens to word; data again wins since no fetch waits
        set_data(AW'('h308), 1'b0, 2'b11);
        serve(1'b1, AW'('h308), 1'b0, 8, -1, -1);

        // fetch request ignored while flush is held in IDLE
        set_fetch(AW'('h500));
        bus.instr_flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_blocks_req", {bus.instr_gnt, bus.mem_start}, 0);
        end
        bus.instr_flush = 1'b0;
        // flush in the grant cycle: grant stands, no nibbles delivered
        serve(1'b0, AW'('h500), 1'b0, 8, 0, -1);
        set_fetch(AW'('h504));
        serve(1'b0, AW'('h504), 1'b0, 8, -1, -1);

        // reset in the middle of a load
        set_data(AW'('h400), 1'b0, SIZE_WORD);
        serve(1'b1, AW'('h400), 1'b0, 8, -1, 4);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 4'h0;
        bus.data_wdata = 4'h0;
        #2 rstn = 1'b0;
        #1;
        check_zero("midreset");
        step();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        prev_data = 1'b0;
        set_data(AW'('h123), 1'b0, SIZE_HALF);
        serve(1'b1, AW'('h123), 1'b0, 4, -1, -1);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            if (!pi && $urandom_range(0, 1) == 1) begin
                pi = 1'b1;
                ia = AW'($urandom);
                set_fetch(ia);
            end
            if (!pd && ($urandom_range(0, 1) == 1 || !pi)) begin
                pd = 1'b1;
                da = AW'($urandom);
                dw = 1'($urandom_range(0, 1));
                ds = 2'($urandom_range(0, 3));
                set_data(da, dw, ds);
            end
            if (pd && (!prev_data || !pi)) begin
                serve(1'b1, da, dw, nib_of(ds), -1, -1);
                pd = 1'b0;
            end else begin
                fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
                serve(1'b0, ia, 1'b0, 8, fl, -1);
                pi = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
